// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset sequencer.
// Contents: FSM state encoding, opcode constants, ALU/PC mux encodings,
// error codes and a small opcode-legality helper.
package multicycle_pkg;

  // FSM states; numeric values are also visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b11;

  // ALU operand selects.
  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_RS      = 1'b1;
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Error codes.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM_TO = 2'b10;
  localparam logic [1:0] ERR_DMEM_TO = 2'b11;

  // True for opcodes that continue into EXEC after DECODE (j is handled in DECODE).
  function automatic logic op_goes_to_exec(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of all control/handshake signals between the sequencer and the
// datapath/memory side.
// master: the sequencer (drives enables, mux selects, status).
// slave : the datapath/memory side (drives opcode, zero flag, ack, start).
//
// Memory handshake: mem_read_o / mem_write_o act as "valid" and are held
// stable, together with iord_o, until mem_ack_i is seen high on a clock edge;
// mem_ack_i is the "ready" and completes the transfer in that same cycle
// (read data is valid in the ack cycle). A request with no ack for TIMEOUT
// cycles is abandoned and the sequencer enters the error state.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [5:0]       op_i;
  logic             zero_i;
  logic             mem_ack_i;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             iord_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic             reg_write_o;
  logic             reg_dst_o;
  logic             mem_to_reg_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_op_o;
  logic [1:0]       pc_source_o;
  logic             busy_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic [2:0]       state_o;     // debug: current FSM state

  modport master (
    input  start_i, op_i, zero_i, mem_ack_i,
    output mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, busy_o, err_o, err_code_o, instr_cnt_o,
           state_o
  );

  modport slave (
    output start_i, op_i, zero_i, mem_ack_i,
    input  mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, busy_o, err_o, err_code_o, instr_cnt_o,
           state_o
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait counter for a memory request awaiting ack.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clear_i      : force counter to zero (asserted whenever no request is pending)
//   en_i         : a request is pending this cycle
//   ack_i        : memory acknowledged this cycle
//   timeout_o    : this is the TIMEOUT-th cycle without ack (ack has priority)
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  input  logic ack_i,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc   = cnt_q + CW'(1);
    // Counts this cycle as a wait; firing on the TIMEOUT-th one.
    timeout_o = en_i && !ack_i && (cnt_inc == CW'(TIMEOUT));
    cnt_d     = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !ack_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath (R-type, addi, lw, sw,
// beq, j). Steps the shared ALU and single memory port through
// FETCH/DECODE/EXEC/MEM/WB, handles variable-latency memory with a timeout,
// counts retired instructions and reports sticky errors.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : master side of multicycle_control_if (opcode, zero flag,
//                  memory ack, start in; datapath enables/selects, status out)
// Control outputs are combinational decodes of the registered state (plus
// ack/zero/opcode where a Mealy decision is needed); all default to 0.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d, boundary_st;
  logic [5:0]       op_q, op_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             timer_en, timeout;

  logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // Only FETCH and MEM wait on memory; everywhere else the timer is held at
  // zero, so it always starts from zero on entry to either state.
  assign timer_en = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!timer_en),
    .en_i      (timer_en),
    .ack_i     (bus.mem_ack_i),
    .timeout_o (timeout)
  );

  // start_i only matters at the end of an instruction.
  assign boundary_st = bus.start_i ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_code_d = err_code_q;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_OP_ADD;
    pc_source  = PC_SRC_ALU;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        iord     = 1'b0;
        // Ack wins over a coinciding timeout.
        if (bus.mem_ack_i) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_OP_ADD;
          pc_source = PC_SRC_ALU;
          state_d   = ST_DECODE;
        end else if (timeout) begin
          err_code_d = ERR_IMEM_TO;
          state_d    = ST_ERR;
        end
      end

      ST_DECODE: begin
        op_d      = bus.op_i;
        // Speculatively compute the branch target into ALUOut.
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_IMM_SH2;
        alu_op    = ALU_OP_ADD;
        if (bus.op_i == OP_J) begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
          retire    = 1'b1;
          state_d   = boundary_st;
        end else if (op_goes_to_exec(bus.op_i)) begin
          state_d = ST_EXEC;
        end else begin
          err_code_d = ERR_ILLEGAL;
          state_d    = ST_ERR;
        end
      end

      ST_EXEC: begin
        alu_src_a = SRC_A_RS;
        case (op_q)
          OP_RTYPE: begin
            alu_src_b = SRC_B_RT;
            alu_op    = ALU_OP_RTYPE;
            state_d   = ST_WB;
          end
          OP_ADDI: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
            state_d   = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
            state_d   = ST_MEM;
          end
          OP_BEQ: begin
            alu_src_b = SRC_B_RT;
            alu_op    = ALU_OP_SUB;
            pc_source = PC_SRC_ALUOUT;
            pc_write  = bus.zero_i;
            retire    = 1'b1;
            state_d   = boundary_st;
          end
          default: begin
            // Unreachable: DECODE only lets legal opcodes through.
            alu_src_a  = SRC_A_PC;
            err_code_d = ERR_ILLEGAL;
            state_d    = ST_ERR;
          end
        endcase
      end

      ST_MEM: begin
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (bus.mem_ack_i) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = boundary_st;
          end
        end else if (timeout) begin
          err_code_d = ERR_DMEM_TO;
          state_d    = ST_ERR;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
        state_d    = boundary_st;
      end

      ST_ERR: begin
        // Sticky until reset; all enables stay low.
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      err_code_q  <= ERR_NONE;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_code_q  <= err_code_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.iord_o       = iord;
  assign bus.ir_write_o   = ir_write;
  assign bus.pc_write_o   = pc_write;
  assign bus.reg_write_o  = reg_write;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.pc_source_o  = pc_source;
  assign bus.busy_o       = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign bus.err_o        = (state_q == ST_ERR);
  assign bus.err_code_o   = err_code_q;
  assign bus.instr_cnt_o  = instr_cnt_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: lock-step driver with a per-cycle control
// vector scoreboard and an independent retire-latency monitor.
module tb_multicycle_control;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4;
  localparam int W       = 17;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;

  typedef enum int {P_IDLE, P_FW, P_FA, P_DEC, P_EXE, P_MW, P_MA, P_WB, P_ERR} phase_e;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 1000000)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           exp_cnt  = 0;
  logic         mon_en   = 1'b0;
  logic [CNT_W-1:0] last_cnt = '0;
  int           cyc_acc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected control vector from the sequencing tables.
  function automatic logic [W-1:0] exp_vec(input phase_e ph, input logic [5:0] op, input logic zero);
    logic mr, mw, io, irw, pcw, rw, rd, m2r, sa, busy, err;
    logic [1:0] sb, ao, ps;
    {mr, mw, io, irw, pcw, rw, rd, m2r, sa, busy, err} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (ph)
      P_FW:  begin mr = 1; busy = 1; end
      P_FA:  begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; busy = 1; end
      P_DEC: begin
        sb = 2'b11; busy = 1;
        if (op == T_J) begin pcw = 1; ps = 2'b10; end
      end
      P_EXE: begin
        busy = 1; sa = 1;
        if (op == T_RTYPE) begin sb = 2'b00; ao = 2'b11; end
        else if (op == T_BEQ) begin sb = 2'b00; ao = 2'b01; ps = 2'b01; pcw = zero; end
        else begin sb = 2'b10; ao = 2'b00; end
      end
      P_MW, P_MA: begin
        busy = 1; io = 1; mr = (op == T_LW); mw = (op == T_SW);
      end
      P_WB:  begin busy = 1; rw = 1; rd = (op == T_RTYPE); m2r = (op == T_LW); end
      P_ERR: begin err = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, rw, rd, m2r, sa, sb, ao, ps, busy, err};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {bus.mem_read_o, bus.mem_write_o, bus.iord_o, bus.ir_write_o,
            bus.pc_write_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
            bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_source_o,
            bus.busy_o, bus.err_o};
  endfunction

  // Retire-latency monitor: a change of instr_cnt_o seen at this negedge
  // means the previous cycle retired; busy cycles since the last retire
  // are the instruction latency.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.instr_cnt_o != last_cnt) begin
        check("lat_q_nonempty", 32'(lat_q.size() != 0), 32'd1);
        if (lat_q.size() != 0) check("latency", 32'(cyc_acc), 32'(lat_q.pop_front()));
        cyc_acc = 0;
      end
      last_cnt = bus.instr_cnt_o;
      if (bus.busy_o) cyc_acc++;
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs for the phase, compare outputs at negedge.
  task automatic step(input phase_e ph, input logic [5:0] op, input logic zero);
    logic ack;
    logic [W-1:0] e;
    if (ph == P_FA || ph == P_MA) ack = 1'b1;
    else if (ph == P_ERR) ack = ($urandom_range(0, 1) != 0);
    else ack = 1'b0;
    bus.mem_ack_i = ack;
    bus.zero_i    = zero;
    // Outside DECODE the opcode bus carries junk; the sequencer must use its latch.
    bus.op_i      = (ph == P_DEC) ? op : 6'($urandom_range(0, 63));
    exp_q.push_back(exp_vec(ph, op, zero));
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("vec_%s", ph.name()), 32'(obs_vec()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    bus.start_i = 1'b1;
    step(P_IDLE, 6'd0, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zero, input int fw,
                           input int mw, input logic stop);
    int base;
    logic is_mem;
    is_mem = (op == T_LW) || (op == T_SW);
    if (op == T_J) base = 2;
    else if (op == T_BEQ) base = 3;
    else if (op == T_LW) base = 5;
    else base = 4;
    lat_q.push_back(base + fw + (is_mem ? mw : 0));
    repeat (fw) step(P_FW, op, zero);
    step(P_FA, op, zero);
    if (stop) bus.start_i = 1'b0;
    step(P_DEC, op, zero);
    if (op != T_J) begin
      step(P_EXE, op, zero);
      if (is_mem) begin
        repeat (mw) step(P_MW, op, zero);
        step(P_MA, op, zero);
      end
      if (op == T_RTYPE || op == T_ADDI || op == T_LW) step(P_WB, op, zero);
    end
    exp_cnt++;
    check("instr_cnt", bus.instr_cnt_o, 32'(exp_cnt));
    if (stop) check("state_idle_after_stop", 32'(bus.state_o), 32'd0);
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.zero_i    = 1'b0;
    bus.op_i      = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_vec", 32'(obs_vec()), 32'(exp_vec(P_IDLE, 6'd0, 1'b0)));
    check("rst_err_code", 32'(bus.err_code_o), 32'd0);
    check("rst_instr_cnt", bus.instr_cnt_o, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_cnt  = 0;
    lat_q.delete();
    last_cnt = '0;
    cyc_acc  = 0;
    mon_en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic err_hold(input logic [1:0] code);
    repeat (3) begin
      step(P_ERR, 6'd0, 1'b0);
      check("err_code", 32'(bus.err_code_o), 32'(code));
    end
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] legal_ops[6];

  initial begin
    legal_ops = '{T_RTYPE, T_ADDI, T_LW, T_SW, T_BEQ, T_J};
    rst_n = 1'b0;
    do_reset();

    // Back-to-back program with immediate acks.
    begin_run();
    run_instr(T_ADDI,  1'b0, 0, 0, 1'b0);
    run_instr(T_RTYPE, 1'b0, 0, 0, 1'b0);
    run_instr(T_SW,    1'b0, 0, 0, 1'b0);
    run_instr(T_LW,    1'b0, 0, 0, 1'b0);
    run_instr(T_BEQ,   1'b1, 0, 0, 1'b0);
    run_instr(T_J,     1'b0, 0, 0, 1'b1);

    // Untaken branch.
    begin_run();
    run_instr(T_BEQ, 1'b0, 0, 0, 1'b1);

    // lw with 3-cycle data ack delay; start dropped mid-instruction.
    begin_run();
    run_instr(T_LW, 1'b0, 0, 3, 1'b1);

    // Random program with variable waits below the timeout.
    begin_run();
    for (int i = 0; i < 8; i++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], ($urandom_range(0, 1) != 0),
                $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), (i == 7));
    end

    // Asynchronous reset while waiting in MEM.
    begin_run();
    step(P_FA, T_LW, 1'b0);
    step(P_DEC, T_LW, 1'b0);
    step(P_EXE, T_LW, 1'b0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state_o), 32'd0);
    check("async_rst_vec", 32'(obs_vec()), 32'(exp_vec(P_IDLE, 6'd0, 1'b0)));
    check("async_rst_cnt", bus.instr_cnt_o, 32'd0);
    do_reset();

    // Illegal opcode.
    begin_run();
    step(P_FA, 6'b111111, 1'b0);
    step(P_DEC, 6'b111111, 1'b0);
    err_hold(2'b01);
    do_reset();

    // Instruction fetch timeout.
    begin_run();
    repeat (TIMEOUT) step(P_FW, 6'd0, 1'b0);
    err_hold(2'b10);
    do_reset();

    // Data memory timeout after a slow fetch (counter must restart in MEM).
    begin_run();
    repeat (TIMEOUT - 1) step(P_FW, T_LW, 1'b0);
    step(P_FA, T_LW, 1'b0);
    step(P_DEC, T_LW, 1'b0);
    step(P_EXE, T_LW, 1'b0);
    repeat (TIMEOUT) step(P_MW, T_LW, 1'b0);
    err_hold(2'b11);
    check("err_instr_cnt", bus.instr_cnt_o, 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("lat_q_drained", 32'(lat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: R-type, addi, lw, sw, beq, j.
- Replaces the single-cycle opcode decode with an FSM that steps the shared ALU and the single memory port through fetch, decode, execute, memory and writeback.
- Handles variable-latency memory through a req/ack handshake, with a timeout.
- Sits between the instruction register (opcode source) and the datapath muxes and enables. Reports retired-instruction count and error status.

Parameters:
- TIMEOUT, 255: maximum cycles a memory request may wait for ack before an error is raised.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable (level); sampled at instruction boundaries.
- op_i  in  6  opcode field from the instruction register (IR[31:26]).
- zero_i  in  1  ALU zero flag.
- mem_ack_i  in  1  memory completion; read data valid this cycle.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  instruction register load enable.
- pc_write_o  out  1  PC load enable (the PC update is computed inside the block).
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  destination register select: 1 = rd, 0 = rt.
- mem_to_reg_o  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- alu_src_a_o  out  1  ALU A operand: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- alu_op_o  out  2  ALU operation: 00 = add, 01 = sub, 11 = R-type (funct decode).
- pc_source_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- busy_o  out  1  high in every state except IDLE and ERR.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  01 = illegal opcode, 10 = instruction-memory timeout, 11 = data-memory timeout.
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE; counters, op_q, err_o and err_code_o cleared.
  - All control outputs are combinational Moore/Mealy decodes of the state and default to 0.
  - Reset mid-instruction aborts with no writes issued.
- IDLE: start_i=1 → FETCH, otherwise stay.
- FETCH: mem_read_o=1, iord_o=0.
  - On mem_ack_i: ir_write_o=1, pc_write_o=1, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_source_o=00; go to DECODE.
  - If the wait counter reaches TIMEOUT with no ack: go to ERR, code 10. If ack and timeout coincide, ack wins.
- DECODE: latch op_q<=op_i; alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00 (branch target into ALUOut).
  - j: pc_write_o=1, pc_source_o=10; retire; go to FETCH, or IDLE if start_i=0.
  - R-type, addi, lw, sw, beq: go to EXEC.
  - Any other opcode: go to ERR, code 01.
- EXEC, decoded from op_q:
  - R-type: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=11 → WB.
  - addi, lw, sw: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00. addi → WB; lw and sw → MEM.
  - beq: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_source_o=01, pc_write_o=zero_i; retire; go to the boundary.
- MEM: iord_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw.
  - Requests are held stable until mem_ack_i.
  - On ack: lw → WB; sw retires and goes to the boundary.
  - Timeout: go to ERR, code 11.
- WB: reg_write_o=1; retire; go to the boundary.
  - R-type: reg_dst_o=1, mem_to_reg_o=0.
  - addi: reg_dst_o=0, mem_to_reg_o=0.
  - lw: reg_dst_o=0, mem_to_reg_o=1.
- Boundary: go to FETCH if start_i=1, else IDLE. start_i is ignored mid-instruction.
- ERR:
  - All enables 0; err_o=1; busy_o=0.
  - Sticky until reset; the error code is written once, on entry.
- Latency with ack in the first cycle: j 2, beq 3, R/addi/sw 4, lw 5. Each extra wait cycle adds 1.
- Wait counter:
  - Width clog2(TIMEOUT+1); cleared on entry to FETCH or MEM; increments each cycle without ack.
  - It never wraps, because it exits to ERR at TIMEOUT.
- instr_cnt_o increments by 1 on every retire and wraps modulo 2^CNT_W.
- No write enable is ever asserted on an invalid opcode.

Decomposition:
- Package multicycle_pkg holds:
  - state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6;
  - opcode constants: 000000, 001000, 100011, 101011, 000100, 000010;
  - the ALUOp, ALU source and PC source encodings;
  - the error codes.
- Sub-module mem_wait_timer (clear, count enable, ack → timeout pulse) is shared by FETCH and MEM.

Test Plan:
- Reset, then start_i=1 and the sequence addi, R-type add, sw, lw, beq (taken), j, with immediate ack → per-instruction cycle counts 4,4,4,5,3,2; exact control vectors per state; instr_cnt_o=6.
- beq with zero_i=0 → pc_write_o=0 in EXEC; beq with zero_i=1 → pc_write_o=1, pc_source_o=01.
- lw with ack delayed 3 cycles in MEM → mem_read_o and iord_o held for 4 cycles; reg_write_o pulses once; total latency 8.
- No ack in FETCH for TIMEOUT=4 → ERR after 4 wait cycles; err_code_o=10; no ir_write_o; stuck until rst_i low.
- op_i=111111 → ERR with err_code_o=01; reg_write_o, mem_write_o and pc_write_o never asserted.
- Drop start_i mid-lw → lw completes and retires, then IDLE. Assert rst_i low during MEM → immediate IDLE, outputs 0, counter 0.
